// File: rtl/pong_pkg.sv
`default_nettype none
// pong_pkg: state encoding, playfield constants and row-mapping helper shared across the pong blocks.
// Rev 1.0
package pong_pkg;

  localparam int PF_ROWS     = 24;
  localparam int SERVE_DELAY = 60;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    OFFER = 2'd2,
    PLAY  = 2'd3
  } serve_state_t;

  // Single conditional subtract; correct only while rows >= 16.
  function automatic logic [4:0] map_row(input logic [4:0] rnd, input int rows);
    if (int'(rnd) < rows) return rnd;
    return 5'(int'(rnd) - rows);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ball_serve_if.sv
`default_nettype none
// ball_serve_if: serve payload handshake between ball_serve and the ball engine.
// Rev 1.0
interface ball_serve_if;
  logic       serve_valid;
  logic       serve_ready;
  logic [4:0] serve_y;
  logic       serve_dx;
  logic       serve_dy;

  modport master (output serve_valid, serve_y, serve_dx, serve_dy, input serve_ready);
  modport slave  (input serve_valid, serve_y, serve_dx, serve_dy, output serve_ready);
endinterface
`default_nettype wire

// File: rtl/frame_countdown.sv
`default_nettype none
// frame_countdown: 8-bit loadable down-counter stepped by frame ticks, saturating at zero.
// Rev 1.0
module frame_countdown (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       i_load,
  input  wire logic [7:0] i_load_value,
  input  wire logic       i_tick,
  output logic            o_zero
);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_tick && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_zero = (r_count == 8'd0);

endmodule
`default_nettype wire

// File: rtl/ball_serve.sv
`default_nettype none
// ball_serve: waits a frame delay after start/goal, then offers a random serve to the ball engine.
// Rev 1.0
module ball_serve
  import pong_pkg::*;
#(
  parameter int ROWS         = PF_ROWS,
  parameter int DELAY_FRAMES = SERVE_DELAY
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       i_frame_tick,
  input  wire logic       i_start,
  input  wire logic       i_goal_left,
  input  wire logic       i_goal_right,
  input  wire logic [4:0] i_rnd_q,
  ball_serve_if.master    serve,
  output logic            o_ball_live
);

  localparam logic [7:0] c_LOAD = 8'(DELAY_FRAMES - 1);

  serve_state_t r_state, w_next_state;
  logic         r_next_dx, w_next_dx;
  logic         w_load, w_capture, w_cnt_tick, w_zero;
  logic         r_valid, r_dx, r_dy, r_live;
  logic [4:0]   r_y;

  assign w_cnt_tick = i_frame_tick && (r_state == HOLD);

  frame_countdown u_countdown (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_load),
    .i_load_value (c_LOAD),
    .i_tick       (w_cnt_tick),
    .o_zero       (w_zero)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_dx    = r_next_dx;
    w_load       = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next_state = HOLD;
          w_next_dx    = i_rnd_q[4];
          w_load       = 1'b1;
        end
      end
      HOLD: begin
        if (i_frame_tick && w_zero) begin
          w_next_state = OFFER;
          w_capture    = 1'b1;
        end
      end
      OFFER: begin
        if (serve.serve_ready) w_next_state = PLAY;
      end
      PLAY: begin
        // Serve heads toward the player who just conceded; left wins a tie.
        if (i_goal_left || i_goal_right) begin
          w_next_state = HOLD;
          w_next_dx    = !i_goal_left;
          w_load       = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_next_dx <= 1'b0;
      r_valid   <= 1'b0;
      r_live    <= 1'b0;
      r_y       <= 5'd0;
      r_dx      <= 1'b0;
      r_dy      <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_next_dx <= w_next_dx;
      r_valid   <= (w_next_state == OFFER);
      r_live    <= (w_next_state == PLAY);
      if (w_capture) begin
        r_y  <= map_row(i_rnd_q, ROWS);
        r_dx <= r_next_dx;
        r_dy <= i_rnd_q[2] ^ i_rnd_q[0];
      end
    end
  end

  assign serve.serve_valid = r_valid;
  assign serve.serve_y     = r_y;
  assign serve.serve_dx    = r_dx;
  assign serve.serve_dy    = r_dy;
  assign o_ball_live       = r_live;

endmodule
`default_nettype wire

// File: tb/tb_ball_serve.sv
`default_nettype none
// tb_ball_serve: scoreboard bench; dut_a uses ROWS=24/DELAY=3, dut_b uses ROWS=32/DELAY=1.
// Rev 1.0
module tb_ball_serve;

  typedef struct packed {
    logic [4:0] y;
    logic       dx;
    logic       dy;
  } pay_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, frame_tick, start, goal_left, goal_right, ready;
  logic [4:0] rnd_q;
  logic       live_a, live_b;

  pay_t q_a[$];
  pay_t q_b[$];
  pay_t e_a, e_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ball_serve_if if_a ();
  ball_serve_if if_b ();
  assign if_a.serve_ready = ready;
  assign if_b.serve_ready = ready;

  ball_serve #(.ROWS(24), .DELAY_FRAMES(3)) dut_a (
    .clk          (clk),
    .reset        (rst_a),
    .i_frame_tick (frame_tick),
    .i_start      (start),
    .i_goal_left  (goal_left),
    .i_goal_right (goal_right),
    .i_rnd_q      (rnd_q),
    .serve        (if_a.master),
    .o_ball_live  (live_a)
  );

  ball_serve #(.ROWS(32), .DELAY_FRAMES(1)) dut_b (
    .clk          (clk),
    .reset        (rst_b),
    .i_frame_tick (frame_tick),
    .i_start      (start),
    .i_goal_left  (goal_left),
    .i_goal_right (goal_right),
    .i_rnd_q      (rnd_q),
    .serve        (if_b.master),
    .o_ball_live  (live_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: a transfer is any non-reset cycle with valid && ready.
  always @(negedge clk) begin
    if (!rst_a && if_a.serve_valid && ready) begin
      if (q_a.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_unexpected_transfer: got y=%0d expected no transfer", if_a.serve_y);
      end else begin
        e_a = q_a.pop_front();
        chk("a_serve_y",  if_a.serve_y,  e_a.y);
        chk("a_serve_dx", if_a.serve_dx, e_a.dx);
        chk("a_serve_dy", if_a.serve_dy, e_a.dy);
      end
    end
    if (!rst_b && if_b.serve_valid && ready) begin
      if (q_b.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_unexpected_transfer: got y=%0d expected no transfer", if_b.serve_y);
      end else begin
        e_b = q_b.pop_front();
        chk("b_serve_y",  if_b.serve_y,  e_b.y);
        chk("b_serve_dx", if_b.serve_dx, e_b.dx);
        chk("b_serve_dy", if_b.serve_dy, e_b.dy);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [4:0] r);
    frame_tick = 1'b1;
    rnd_q      = r;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic goal(input logic l, input logic r);
    goal_left  = l;
    goal_right = r;
    cyc();
    goal_left  = 1'b0;
    goal_right = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; frame_tick = 1'b0; start = 1'b0;
    goal_left = 1'b0; goal_right = 1'b0; ready = 1'b0; rnd_q = 5'd0;
    cyc(); cyc();

    // ---------------- dut_a: ROWS=24, DELAY_FRAMES=3 ----------------
    chk("rst_valid", if_a.serve_valid, 0);
    chk("rst_y",     if_a.serve_y,     0);
    chk("rst_dx",    if_a.serve_dx,    0);
    chk("rst_dy",    if_a.serve_dy,    0);
    chk("rst_live",  live_a,           0);
    rst_a = 1'b0;

    start = 1'b1; rnd_q = 5'b10110; cyc(); start = 1'b0;
    tick(5'b00001);
    tick(5'b00011);
    chk("hold_valid", if_a.serve_valid, 0);
    q_a.push_back('{y: 5'd2, dx: 1'b1, dy: 1'b0});
    tick(5'b11010);
    chk("offer_rise", if_a.serve_valid, 1);

    for (int i = 0; i < 5; i++) begin
      frame_tick = i[0];
      rnd_q      = 5'(i * 7 + 3);
      cyc();
      chk("stall_valid", if_a.serve_valid, 1);
      chk("stall_y",     if_a.serve_y,     2);
      chk("stall_dx",    if_a.serve_dx,    1);
      chk("stall_dy",    if_a.serve_dy,    0);
    end
    frame_tick = 1'b0;
    ready = 1'b1; cyc(); ready = 1'b0;
    chk("xfer_valid", if_a.serve_valid, 0);
    chk("xfer_live",  live_a,           1);

    goal(1'b1, 1'b1);
    chk("goal_live", live_a, 0);
    start = 1'b1; cyc(); start = 1'b0;
    tick(5'd0);
    tick(5'd0);
    chk("hold2_valid", if_a.serve_valid, 0);
    q_a.push_back('{y: 5'd4, dx: 1'b0, dy: 1'b1});
    tick(5'b00100);
    chk("offer2_valid", if_a.serve_valid, 1);
    ready = 1'b1; cyc(); ready = 1'b0;
    chk("xfer2_live", live_a, 1);
    start = 1'b1; cyc(); start = 1'b0;
    chk("play_start_live",  live_a,           1);
    chk("play_start_valid", if_a.serve_valid, 0);

    // Row sweep, ready already high when valid first rises.
    for (int r = 0; r < 32; r++) begin
      logic [4:0] rv;
      rv = 5'(r);
      goal(rv[0], !rv[0]);
      tick(5'd31);
      tick(5'd31);
      q_a.push_back('{y: (r < 24) ? 5'(r) : 5'(r - 24), dx: !rv[0], dy: rv[2] ^ rv[0]});
      ready = 1'b1;
      tick(rv);
      chk("sweep_valid", if_a.serve_valid, 1);
      cyc();
      ready = 1'b0;
      chk("sweep_valid_drop", if_a.serve_valid, 0);
      chk("sweep_live",       live_a,           1);
    end

    // Reset during OFFER with ready high: no transfer may be recorded.
    goal(1'b1, 1'b0);
    tick(5'd0);
    tick(5'd0);
    tick(5'b01001);
    chk("offer3_valid", if_a.serve_valid, 1);
    rst_a = 1'b1; ready = 1'b1;
    cyc();
    chk("rst_offer_valid", if_a.serve_valid, 0);
    chk("rst_offer_live",  live_a,           0);
    chk("rst_offer_y",     if_a.serve_y,     0);
    rst_a = 1'b0; ready = 1'b0;
    goal(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(5'd0);
    chk("idle_goal_valid", if_a.serve_valid, 0);
    chk("idle_goal_live",  live_a,           0);
    rst_a = 1'b1;

    // ---------------- dut_b: ROWS=32, DELAY_FRAMES=1 ----------------
    rst_b = 1'b1; cyc(); rst_b = 1'b0;
    start = 1'b1; frame_tick = 1'b1; rnd_q = 5'b00000;
    cyc();
    start = 1'b0; frame_tick = 1'b0;
    chk("b_same_cycle_valid", if_b.serve_valid, 0);
    cyc();
    chk("b_no_tick_valid", if_b.serve_valid, 0);
    q_b.push_back('{y: 5'd31, dx: 1'b0, dy: 1'b0});
    tick(5'b11111);
    chk("b_offer_valid", if_b.serve_valid, 1);
    ready = 1'b1; cyc(); ready = 1'b0;
    chk("b_xfer_live", live_b, 1);

    for (int r = 0; r < 32; r++) begin
      logic [4:0] rv;
      rv = 5'(r);
      goal(1'b0, 1'b1);
      q_b.push_back('{y: rv, dx: 1'b1, dy: rv[2] ^ rv[0]});
      ready = 1'b1;
      tick(rv);
      chk("b_sweep_valid", if_b.serve_valid, 1);
      cyc();
      ready = 1'b0;
      chk("b_sweep_live", live_b, 1);
    end
    start = 1'b1; cyc(); start = 1'b0;
    chk("b_play_start_live", live_b, 1);

    cyc();
    chk("a_queue_empty", q_a.size(), 0);
    chk("b_queue_empty", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ball_serve.md
Name: ball_serve

Overview:
- Consumes the 5-bit LFSR value from the pseudo-random generator.
- Decides when and how the ball is (re)served: the row, the horizontal direction and the vertical direction.
- Sits between the random generator and the ball-motion engine.
- Waits a fixed number of frames after game start or after a goal, then offers the serve to the ball engine over a valid/ready handshake.

Parameters:
- ROWS, 24: number of playfield rows; legal range 16..32; serve_y is always < ROWS.
- DELAY_FRAMES, 60: frame_tick pulses between entering HOLD and offering the serve; legal range 1..255.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- frame_tick  input  1  one-cycle pulse per video frame
- start  input  1  pulse; begins a game from IDLE
- goal_left  input  1  pulse; left player conceded a point
- goal_right  input  1  pulse; right player conceded a point
- rnd_q  input  5  current LFSR output
- serve_ready  input  1  ball engine can accept a serve
- serve_valid  output  1  serve payload is offered
- serve_y  output  5  initial ball row, 0..ROWS-1
- serve_dx  output  1  horizontal direction; 1 = rightward
- serve_dy  output  1  vertical direction; 1 = downward
- ball_live  output  1  ball in play (PLAY state)

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high.
- Reset values: state IDLE, counter 0, serve_valid 0, serve_y 0, serve_dx 0, serve_dy 0, ball_live 0.
- States: IDLE, HOLD, OFFER, PLAY. All outputs are registered.
- IDLE:
  - On start, go to HOLD.
  - Latch next_dx = rnd_q[4].
  - Load counter = DELAY_FRAMES-1.
  - goal_* and serve_ready are ignored.
- HOLD:
  - On frame_tick with counter != 0: decrement the counter.
  - On frame_tick with counter == 0: go to OFFER.
  - In that same cycle capture the payload:
    - serve_y = rnd_q if rnd_q < ROWS, else rnd_q - ROWS.
    - serve_dy = rnd_q[2] ^ rnd_q[0].
    - serve_dx = next_dx.
  - serve_valid rises the following cycle, i.e. one cycle after the final frame_tick.
- OFFER:
  - serve_valid = 1. serve_y, serve_dx and serve_dy are held stable until transfer.
  - Transfer occurs in any cycle with serve_valid && serve_ready.
  - On transfer: next cycle serve_valid = 0, ball_live = 1, state PLAY.
  - If serve_ready is already high on the first valid cycle, the transfer takes exactly one cycle.
  - frame_tick is ignored while in OFFER.
- PLAY:
  - On goal_left: next_dx = 0 (serve heads toward the conceding left player).
  - On goal_right: next_dx = 1.
  - Either goal loads counter = DELAY_FRAMES-1, sets ball_live = 0 the next cycle, and moves to HOLD.
- Boundary conditions:
  - goal_left and goal_right in the same cycle: goal_left wins.
  - goal_* outside PLAY: ignored.
  - start outside IDLE: ignored.
  - start and frame_tick in the same cycle in IDLE: the tick is not counted.
  - DELAY_FRAMES = 1: counter loads 0, so the first frame_tick in HOLD triggers OFFER.
  - Payload row mapping is a single conditional subtract. Valid only because ROWS >= 16; ROWS = 32 passes rnd_q through unchanged.
  - reset asserted mid-HOLD, mid-OFFER (even with serve_ready = 1) or mid-PLAY: all outputs take reset values in the next cycle and no transfer occurs.
  - The block never returns to IDLE except via reset.

Decomposition:
- Shared package pong_pkg:
  - serve_state_t enum (IDLE, HOLD, OFFER, PLAY)
  - constants PF_ROWS = 24 and SERVE_DELAY = 60, used by the ball engine and renderer too
- One sub-module, frame_countdown:
  - Ports: load, load_value[7:0], tick, zero.
  - Contains the 8-bit down-counter used in HOLD.
- FSM and payload capture stay in ball_serve.

Test Plan:
- Reset, then start with rnd_q = 5'b10110 and DELAY_FRAMES = 3; then 3 frame_ticks with rnd_q = 5'b11010 on the last tick -> serve_valid = 1 exactly one cycle after the third tick, serve_y = 2 (26 - 24), serve_dy = 0, serve_dx = 1.
- In OFFER, hold serve_ready = 0 for 5 cycles while rnd_q and frame_tick toggle -> payload and serve_valid unchanged. Raise serve_ready -> serve_valid = 0 and ball_live = 1 next cycle.
- In PLAY, pulse goal_left and goal_right in the same cycle -> HOLD, ball_live = 0, next serve has serve_dx = 0.
- Sweep rnd_q 0..31 at the capture tick with ROWS = 24 -> serve_y = rnd_q for 0..23 and rnd_q - 24 for 24..31. Repeat with ROWS = 32 -> serve_y = rnd_q.
- Assert reset during OFFER with serve_ready = 1 -> no transfer; next cycle serve_valid = 0, ball_live = 0, state IDLE. A goal pulse afterwards is ignored.
- DELAY_FRAMES = 1, start then a single frame_tick -> serve_valid asserts the cycle after that tick. Extra start pulses in HOLD/PLAY have no effect.
